// File: rtl/imem_writer_if.sv
`timescale 1ns/1ps
// imem_writer_if
//   Bundles every non-clock/reset signal of the instruction-memory loader.
//   The word stream, the session control and the byte-wide memory write port
//   all live here.
//
//   Handshake: a word transfer happens on a rising clk edge where valid_i and
//   ready_o are both 1. The producer keeps word_i/last_i stable while valid_i
//   is high. The loader raises ready_o only while it waits for a word.
//
//   Signals (named from the loader's point of view):
//     start_i  : one-cycle pulse that opens a load session
//     base_i   : first byte address of the session, sampled with start_i
//     word_i   : 32-bit instruction word
//     valid_i  : word_i / last_i are valid
//     last_i   : the offered word is the final word of the session
//     ready_o  : loader accepts word_i this cycle
//     we_o     : byte write enable to the memory
//     wa_o     : byte write address (0 unless we_o)
//     wd_o     : byte write data (0 unless we_o)
//     busy_o   : session in progress
//     done_o   : one-cycle pulse, session completed normally
//     err_o    : sticky, session aborted on address overflow
//     count_o  : words fully written in the current or last session
//     state_o  : current FSM state, for debug and checker binding
//   Modports:
//     slave  : the loader itself
//     master : the word producer / session controller
interface imem_writer_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 8
);
    logic                     start_i;
    logic [ADDRESS_WIDTH-1:0] base_i;
    logic [31:0]              word_i;
    logic                     valid_i;
    logic                     last_i;
    logic                     ready_o;
    logic                     we_o;
    logic [ADDRESS_WIDTH-1:0] wa_o;
    logic [DATA_WIDTH-1:0]    wd_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     err_o;
    logic [15:0]              count_o;
    logic [1:0]               state_o;

    modport slave (
        input  start_i, base_i, word_i, valid_i, last_i,
        output ready_o, we_o, wa_o, wd_o, busy_o, done_o, err_o, count_o,
        output state_o
    );

    modport master (
        output start_i, base_i, word_i, valid_i, last_i,
        input  ready_o, we_o, wa_o, wd_o, busy_o, done_o, err_o, count_o,
        input  state_o
    );
endinterface

// File: rtl/imem_writer.sv
`timescale 1ns/1ps
// imem_writer
//   Loads 32-bit instruction words into a byte-wide instruction memory.
//   A session opens with start_i and base_i. Each word accepted through the
//   valid/ready handshake is written as four bytes on four consecutive cycles.
//   The byte order is big-endian: word[31:24] goes to the lowest address. This
//   matches the 4-byte big-endian fetch of the instruction ROM. A byte whose
//   address falls outside the memory aborts the session and sets the sticky
//   err_o.
//
//   Ports:
//     clk  : clock, all state changes on the rising edge
//     rst  : asynchronous, active-high reset
//     bus  : imem_writer_if.slave (session control, word stream, write port,
//            status and debug state)
//
//   Timing: a word accepted at cycle N produces writes in cycles N+1..N+4.
//   With valid_i held high, the next handshake occurs in cycle N+5.
module imem_writer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 28
) (
    input  logic          clk,
    input  logic          rst,
    imem_writer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Highest legal byte address. It is kept one bit wider than the address
    // so that it can be compared against the carry-extended address below.
    localparam logic [ADDRESS_WIDTH:0] LAST_ADDR = (ADDRESS_WIDTH+1)'(DEPTH - 1);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] ptr;       // address of byte 0 of the current word
    logic [31:0]              word_q;    // word being written
    logic                     last_q;    // word_q closes the session
    logic [1:0]               idx;       // byte index within word_q
    logic                     ready_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;
    logic [15:0]              count_q;

    // Byte address of the current WRITE cycle. The extra MSB catches a wrap
    // past 2^ADDRESS_WIDTH. A wrapped address therefore compares above
    // LAST_ADDR and fails the bounds check, just as an ordinary out-of-range
    // address does.
    logic [ADDRESS_WIDTH:0] addr_ext;
    logic                   in_bounds;
    logic [7:0]             byte_sel;
    logic                   we_int;

    assign addr_ext  = {1'b0, ptr} + {{(ADDRESS_WIDTH-1){1'b0}}, idx};
    assign in_bounds = (addr_ext <= LAST_ADDR);
    assign we_int    = (state == WRITE) && in_bounds;

    // Big-endian byte lane select.
    always_comb begin
        byte_sel = 8'h00;
        case (idx)
            2'd0: byte_sel = word_q[31:24];
            2'd1: byte_sel = word_q[23:16];
            2'd2: byte_sel = word_q[15:8];
            2'd3: byte_sel = word_q[7:0];
            default: byte_sel = 8'h00;
        endcase
    end

    // The write port is decoded from registered state only. The address and
    // data are forced to 0 whenever no write happens. Because state is reset
    // asynchronously, the write stops in the same cycle rst rises.
    assign bus.we_o    = we_int;
    assign bus.wa_o    = we_int ? addr_ext[ADDRESS_WIDTH-1:0] : '0;
    assign bus.wd_o    = we_int ? DATA_WIDTH'(byte_sel) : '0;

    assign bus.ready_o = ready_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.err_o   = err_q;
    assign bus.count_o = count_q;
    assign bus.state_o = state;

    // Single FSM. The status flags ready/busy/done are registered together
    // with the state transition. Each flag therefore always matches the state
    // being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            idx     <= 2'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= 16'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // err/count keep the result of the last session until a
                    // new one opens.
                    if (bus.start_i) begin
                        ptr     <= bus.base_i;
                        count_q <= 16'd0;
                        err_q   <= 1'b0;
                        state   <= WAIT;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                WAIT: begin
                    if (bus.valid_i) begin
                        word_q  <= bus.word_i;
                        last_q  <= bus.last_i;
                        idx     <= 2'd0;
                        state   <= WRITE;
                        ready_q <= 1'b0;
                    end
                end

                WRITE: begin
                    if (!in_bounds) begin
                        // Abort: the current byte was suppressed and the
                        // partial word is not counted.
                        err_q  <= 1'b1;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (idx == 2'd3) begin
                        ptr <= ptr + ADDRESS_WIDTH'(4);
                        if (count_q != 16'hFFFF) begin
                            count_q <= count_q + 16'd1;
                        end
                        if (last_q) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_writer.sv
`timescale 1ns/1ps
// tb_imem_writer
//   Directed bench for imem_writer with a 28-byte memory and 32-bit addresses.
//   Inputs change 1 ns after the rising edge. Outputs are sampled at the same
//   point, which is well away from the next active edge.
module tb_imem_writer;

    localparam int AW = 32;
    localparam int DW = 8;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    imem_writer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    imem_writer #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (28)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit: the run needs only a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start_i = 1'b0;
        bus.base_i  = '0;
        bus.word_i  = '0;
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    task automatic open_session(input logic [AW-1:0] base);
        bus.start_i = 1'b1;
        bus.base_i  = base;
        step();
        bus.start_i = 1'b0;
        bus.base_i  = '0;
    endtask

    task automatic offer_word(input logic [31:0] w, input logic lst);
        bus.valid_i = 1'b1;
        bus.word_i  = w;
        bus.last_i  = lst;
        step();
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if ({bus.ready_o, bus.we_o, bus.wa_o, bus.wd_o, bus.busy_o, bus.done_o,
             bus.err_o, bus.count_o, bus.state_o} !== 63'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got we=%b wa=%h wd=%h ready=%b busy=%b done=%b err=%b count=%0d state=%0d, expected all 0",
                     bus.we_o, bus.wa_o, bus.wd_o, bus.ready_o, bus.busy_o, bus.done_o,
                     bus.err_o, bus.count_o, bus.state_o);
        end
        rst = 1'b0;
        step();
        step();
        tests_run++;
        if ({bus.busy_o, bus.ready_o, bus.state_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got busy=%b ready=%b state=%0d, expected 0 0 0",
                     bus.busy_o, bus.ready_o, bus.state_o);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp_b [4];
        exp_b = '{8'h00, 8'hA0, 8'h00, 8'h93};
        open_session(32'd0);
        tests_run++;
        if ({bus.ready_o, bus.busy_o, bus.err_o, bus.count_o} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
            tests_failed++;
            $display("FAIL single_wait: got ready=%b busy=%b err=%b count=%0d, expected 1 1 0 0",
                     bus.ready_o, bus.busy_o, bus.err_o, bus.count_o);
        end
        offer_word(32'h00A00093, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({bus.we_o, bus.wa_o, bus.wd_o, bus.ready_o} !== {1'b1, 32'(i), exp_b[i], 1'b0}) begin
                tests_failed++;
                $display("FAIL single_byte%0d: got we=%b wa=%h wd=%h ready=%b, expected 1 %h %h 0",
                         i, bus.we_o, bus.wa_o, bus.wd_o, bus.ready_o, 32'(i), exp_b[i]);
            end
            step();
        end
        tests_run++;
        if ({bus.done_o, bus.busy_o, bus.we_o, bus.count_o} !== {1'b1, 1'b1, 1'b0, 16'd1}) begin
            tests_failed++;
            $display("FAIL single_done: got done=%b busy=%b we=%b count=%0d, expected 1 1 0 1",
                     bus.done_o, bus.busy_o, bus.we_o, bus.count_o);
        end
        step();
        tests_run++;
        if ({bus.done_o, bus.busy_o, bus.err_o, bus.count_o, bus.state_o} !==
            {1'b0, 1'b0, 1'b0, 16'd1, 2'd0}) begin
            tests_failed++;
            $display("FAIL single_idle: got done=%b busy=%b err=%b count=%0d state=%0d, expected 0 0 0 1 0",
                     bus.done_o, bus.busy_o, bus.err_o, bus.count_o, bus.state_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [7];
        logic [31:0] w;
        logic [7:0]  exp_d;
        int k, writes, cyc, last_ready, gap_bad, ready_cnt, addr_bad;
        logic done_seen;
        logic [15:0] count_at_done;
        logic err_at_done;
        words = '{32'h00A00093, 32'h00100113, 32'h002081B3, 32'hFE010113,
                  32'h00112623, 32'h00C12083, 32'h00008067};
        k = 0; writes = 0; cyc = 0; last_ready = -1; gap_bad = 0;
        ready_cnt = 0; addr_bad = 0; done_seen = 1'b0;
        count_at_done = 16'd0; err_at_done = 1'b0;
        open_session(32'd0);
        bus.valid_i = 1'b1;
        while (!done_seen && cyc < 80) begin
            if (bus.ready_o) begin
                if (last_ready >= 0 && (cyc - last_ready) != 5) gap_bad++;
                last_ready = cyc;
                ready_cnt++;
                if (k < 7) begin
                    bus.word_i = words[k];
                    bus.last_i = (k == 6);
                    k++;
                end
            end
            if (bus.we_o) begin
                w = words[writes / 4];
                exp_d = w[31 - 8 * (writes % 4) -: 8];
                if (bus.wa_o !== 32'(writes) || bus.wd_o !== exp_d) begin
                    addr_bad++;
                    $display("FAIL b2b_write%0d: got wa=%h wd=%h, expected %h %h",
                             writes, bus.wa_o, bus.wd_o, 32'(writes), exp_d);
                end
                writes++;
            end
            if (bus.done_o) begin
                done_seen = 1'b1;
                count_at_done = bus.count_o;
                err_at_done = bus.err_o;
            end
            step();
            cyc++;
        end
        bus.valid_i = 1'b0;
        bus.last_i = 1'b0;
        tests_run++;
        if (done_seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_done: done_o not seen within 80 cycles, expected a pulse");
        end
        tests_run++;
        if (writes !== 28 || addr_bad !== 0) begin
            tests_failed++;
            $display("FAIL b2b_writes: got %0d writes with %0d bad, expected 28 with 0 bad", writes, addr_bad);
        end
        tests_run++;
        if (ready_cnt !== 7 || gap_bad !== 0) begin
            tests_failed++;
            $display("FAIL b2b_ready_cadence: got %0d ready cycles with %0d gaps not equal to 5, expected 7 and 0",
                     ready_cnt, gap_bad);
        end
        tests_run++;
        if ({count_at_done, err_at_done} !== {16'd7, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_count: got count=%0d err=%b, expected 7 0", count_at_done, err_at_done);
        end
        step();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b [4];
        exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        open_session(32'd24);
        offer_word(32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({bus.we_o, bus.wa_o, bus.wd_o} !== {1'b1, 32'(24 + i), exp_b[i]}) begin
                tests_failed++;
                $display("FAIL ovf_byte%0d: got we=%b wa=%h wd=%h, expected 1 %h %h",
                         i, bus.we_o, bus.wa_o, bus.wd_o, 32'(24 + i), exp_b[i]);
            end
            step();
        end
        tests_run++;
        if ({bus.ready_o, bus.count_o, bus.err_o} !== {1'b1, 16'd1, 1'b0}) begin
            tests_failed++;
            $display("FAIL ovf_wait: got ready=%b count=%0d err=%b, expected 1 1 0",
                     bus.ready_o, bus.count_o, bus.err_o);
        end
        offer_word(32'h12345678, 1'b1);
        tests_run++;
        if ({bus.we_o, bus.wa_o, bus.wd_o, bus.state_o} !== {1'b0, 32'd0, 8'd0, 2'd2}) begin
            tests_failed++;
            $display("FAIL ovf_blocked: got we=%b wa=%h wd=%h state=%0d, expected 0 0 0 2",
                     bus.we_o, bus.wa_o, bus.wd_o, bus.state_o);
        end
        step();
        tests_run++;
        if ({bus.err_o, bus.busy_o, bus.ready_o, bus.count_o, bus.state_o} !==
            {1'b1, 1'b0, 1'b0, 16'd1, 2'd0}) begin
            tests_failed++;
            $display("FAIL ovf_abort: got err=%b busy=%b ready=%b count=%0d state=%0d, expected 1 0 0 1 0",
                     bus.err_o, bus.busy_o, bus.ready_o, bus.count_o, bus.state_o);
        end
        // err/count hold in IDLE; stray words are ignored.
        bus.valid_i = 1'b1;
        bus.word_i = 32'hFFFFFFFF;
        step(); step(); step();
        bus.valid_i = 1'b0;
        tests_run++;
        if ({bus.err_o, bus.count_o, bus.we_o, bus.state_o} !== {1'b1, 16'd1, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got err=%b count=%0d we=%b state=%0d, expected 1 1 0 0",
                     bus.err_o, bus.count_o, bus.we_o, bus.state_o);
        end
        open_session(32'd0);
        tests_run++;
        if ({bus.err_o, bus.count_o, bus.state_o} !== {1'b0, 16'd0, 2'd1}) begin
            tests_failed++;
            $display("FAIL ovf_restart_clear: got err=%b count=%0d state=%0d, expected 0 0 1",
                     bus.err_o, bus.count_o, bus.state_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        // Byte 0 lies at 0xFFFFFFFD. Later bytes would wrap to 0, but byte 0 is
        // already out of range.
        open_session(32'hFFFFFFFD);
        offer_word(32'h11223344, 1'b1);
        tests_run++;
        if ({bus.we_o, bus.wa_o, bus.wd_o} !== {1'b0, 32'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL wrap_blocked: got we=%b wa=%h wd=%h, expected 0 0 0",
                     bus.we_o, bus.wa_o, bus.wd_o);
        end
        step();
        tests_run++;
        if ({bus.err_o, bus.state_o, bus.count_o, bus.done_o} !== {1'b1, 2'd0, 16'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL wrap_abort: got err=%b state=%0d count=%0d done=%b, expected 1 0 0 0",
                     bus.err_o, bus.state_o, bus.count_o, bus.done_o);
        end
    endtask

    task automatic test_wait_stall();
        int bad;
        bad = 0;
        open_session(32'd8);
        for (int i = 0; i < 10; i++) begin
            if ({bus.we_o, bus.busy_o, bus.ready_o} !== 3'b011) bad++;
            step();
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL stall_wait: got %0d of 10 cycles not showing we=0 busy=1 ready=1, expected 0", bad);
        end
        offer_word(32'hCAFEF00D, 1'b1);
        tests_run++;
        if ({bus.we_o, bus.wa_o, bus.wd_o} !== {1'b1, 32'd8, 8'hCA}) begin
            tests_failed++;
            $display("FAIL stall_first_byte: got we=%b wa=%h wd=%h, expected 1 8 ca",
                     bus.we_o, bus.wa_o, bus.wd_o);
        end
        step(); step(); step(); step();
        tests_run++;
        if ({bus.done_o, bus.count_o} !== {1'b1, 16'd1}) begin
            tests_failed++;
            $display("FAIL stall_done: got done=%b count=%0d, expected 1 1", bus.done_o, bus.count_o);
        end
        step();
    endtask

    task automatic test_reset_mid_write();
        int bad;
        bad = 0;
        open_session(32'd0);
        offer_word(32'hA1B2C3D4, 1'b1);
        step();
        tests_run++;
        if ({bus.we_o, bus.wa_o, bus.wd_o} !== {1'b1, 32'd1, 8'hB2}) begin
            tests_failed++;
            $display("FAIL rstw_second_byte: got we=%b wa=%h wd=%h, expected 1 1 b2",
                     bus.we_o, bus.wa_o, bus.wd_o);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.ready_o, bus.we_o, bus.wa_o, bus.wd_o, bus.busy_o, bus.done_o,
             bus.err_o, bus.count_o, bus.state_o} !== 63'd0) begin
            tests_failed++;
            $display("FAIL rstw_immediate: got we=%b wa=%h wd=%h busy=%b count=%0d state=%0d, expected all 0",
                     bus.we_o, bus.wa_o, bus.wd_o, bus.busy_o, bus.count_o, bus.state_o);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if ({bus.we_o, bus.state_o, bus.busy_o} !== 4'b0000) bad++;
            step();
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL rstw_after: got %0d cycles with a write or non-IDLE state, expected 0", bad);
        end
    endtask

    task automatic test_start_in_write();
        logic [7:0] exp_b [4];
        exp_b = '{8'h01, 8'h23, 8'h45, 8'h67};
        open_session(32'd4);
        offer_word(32'h01234567, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                bus.start_i = 1'b1;
                bus.base_i = 32'd16;
            end else begin
                bus.start_i = 1'b0;
                bus.base_i = '0;
            end
            tests_run++;
            if ({bus.we_o, bus.wa_o, bus.wd_o} !== {1'b1, 32'(4 + i), exp_b[i]}) begin
                tests_failed++;
                $display("FAIL sw_byte%0d: got we=%b wa=%h wd=%h, expected 1 %h %h",
                         i, bus.we_o, bus.wa_o, bus.wd_o, 32'(4 + i), exp_b[i]);
            end
            step();
        end
        bus.start_i = 1'b0;
        tests_run++;
        if ({bus.done_o, bus.count_o} !== {1'b1, 16'd1}) begin
            tests_failed++;
            $display("FAIL sw_done: got done=%b count=%0d, expected 1 1", bus.done_o, bus.count_o);
        end
        step();
        step();
        tests_run++;
        if ({bus.state_o, bus.busy_o, bus.count_o} !== {2'd0, 1'b0, 16'd1}) begin
            tests_failed++;
            $display("FAIL sw_idle: got state=%0d busy=%b count=%0d, expected 0 0 1",
                     bus.state_o, bus.busy_o, bus.count_o);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_wait_stall();
        test_reset_mid_write();
        test_start_in_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imem_writer.md
IMEM_WRITER -- requirements
Module: imem_writer

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: width of the byte address.
REQ-002 Parameter DATA_WIDTH, default 8: width of one memory byte lane.
REQ-003 Parameter DEPTH, default 28: number of bytes in the target instruction memory.
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port start_i  input  1  one-cycle pulse that opens a load session.
REQ-007 Port base_i  input  ADDRESS_WIDTH  first byte address of the session, sampled with start_i.
REQ-008 Port word_i  input  32  instruction word to store.
REQ-009 Port valid_i  input  1  word_i (and last_i) is valid.
REQ-010 Port last_i  input  1  the word offered is the final word of the session.
REQ-011 Port ready_o  output  1  block accepts word_i this cycle.
REQ-012 Port we_o  output  1  byte write enable to memory.
REQ-013 Port wa_o  output  ADDRESS_WIDTH  byte write address.
REQ-014 Port wd_o  output  DATA_WIDTH  byte write data.
REQ-015 Port busy_o  output  1  session in progress.
REQ-016 Port done_o  output  1  one-cycle pulse: session completed normally.
REQ-017 Port err_o  output  1  sticky: session aborted on address overflow.
REQ-018 Port count_o  output  16  number of words fully written in the current or last session.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT, WRITE, DONE.
REQ-020 IDLE: start_i=1 -> latch base_i into the address pointer, clear count_o and err_o, go to WAIT; other inputs ignored.
REQ-021 WAIT: ready_o=1; a handshake occurs when valid_i and ready_o are both 1; on handshake, latch word_i and last_i, set byte index to 0, go to WRITE.
REQ-022 ready_o SHALL be 0 in every state other than WAIT.
REQ-023 WRITE: one byte per cycle, 4 cycles per word, big-endian: index 0 writes word[31:24] at ptr, 1 writes word[23:16] at ptr+1, 2 writes word[15:8] at ptr+2, 3 writes word[7:0] at ptr+3 (matches the 4-byte big-endian fetch of the instruction ROM).
REQ-024 we_o SHALL be 1 exactly in WRITE cycles that pass the bounds check; wa_o and wd_o are valid only when we_o=1 and are 0 otherwise.
REQ-025 After index 3: ptr += 4, count_o += 1; if the latched last=1 go to DONE, otherwise go to WAIT.
REQ-026 Bounds check: if a WRITE cycle's address is greater than DEPTH-1, that byte SHALL NOT be written (we_o=0), err_o SHALL be set, and the FSM SHALL go to IDLE without incrementing count_o.
REQ-027 Address arithmetic is modulo 2^ADDRESS_WIDTH; an address that wraps SHALL fail the bounds check.
REQ-028 DONE: done_o=1 for exactly one cycle, then go to IDLE.
REQ-029 busy_o SHALL be 1 in WAIT, WRITE and DONE, and 0 in IDLE.
REQ-030 start_i outside IDLE SHALL be ignored.
REQ-031 count_o saturates at 16'hFFFF.
REQ-032 Latency: a word accepted at cycle N SHALL produce writes in cycles N+1..N+4; with valid_i held high, the next handshake occurs in cycle N+5.
REQ-033 err_o and count_o SHALL hold their values in IDLE until the next accepted start_i.

Reset
REQ-034 rst=1 at any time SHALL immediately force IDLE; ready_o, we_o, wa_o, wd_o, busy_o, done_o, err_o and count_o go to 0, and the pointer and latched word are cleared.
REQ-035 Reset during WRITE SHALL abort the word; no further bytes are written after rst asserts.

Verification
REQ-036 start_i with base_i=0; one word 32'h00A00093 with last_i=1 -> bytes 00,A0,00,93 written at addresses 0..3 on consecutive cycles; done_o pulses; count_o=1.
REQ-037 Seven back-to-back words from base 0 with valid_i held high, last word flagged -> 28 writes, ready_o high once every 5 cycles, count_o=7, err_o=0.
REQ-038 base_i=24, two words -> first word written at addresses 24..27; second word's first byte at 28 is blocked (we_o=0), err_o=1, return to IDLE, count_o=1.
REQ-039 valid_i held low for 10 cycles in WAIT -> no writes, busy_o=1, ready_o=1 throughout.
REQ-040 rst asserted during the 2nd byte of a word -> all outputs 0 in that same cycle; no write to ptr+2; FSM in IDLE after rst deasserts.
REQ-041 start_i pulsed while in WRITE -> ignored; address sequence and count_o unchanged.
